// File: rtl/pram_arb_pkg.sv
// pram_arb_pkg: shared types and constants for the PRAM arbiter.
//   arb_state_t - arbiter sequencing states
//   owner_t     - which side currently drives the RTC serial bus
//   PRAM_NBYTES - PRAM bytes moved per dump/restore job
//   CMD_*       - RTC command byte fields; pram_cmd() builds a full command
package pram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUS,
    CS_SETUP,
    SHIFT_CMD,
    SHIFT_DATA,
    CS_RELEASE,
    NEXT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_VIA,
    OWNER_HOST
  } owner_t;

  localparam int PRAM_NBYTES = 20;

  localparam int         CMD_READ_BIT  = 7;       // 1 = read from RTC
  localparam logic       CMD_LO_PREFIX = 1'b1;    // bytes 0..15: z1aaaa01
  localparam logic [2:0] CMD_HI_PREFIX = 3'b010;  // bytes 16..19: z010aa01
  localparam logic [1:0] CMD_SUFFIX    = 2'b01;

  // rd=1 builds a read (dump) command, rd=0 a write (restore) command.
  function automatic logic [7:0] pram_cmd(input logic rd, input logic [4:0] idx);
    logic [7:0] cmd;
    if (idx[4]) cmd = {1'b0, CMD_HI_PREFIX, idx[1:0], CMD_SUFFIX};
    else        cmd = {1'b0, CMD_LO_PREFIX, idx[3:0], CMD_SUFFIX};
    cmd[CMD_READ_BIT] = rd;
    return cmd;
  endfunction

endpackage

// File: rtl/pram_arb_shifter.sv
// pram_shifter: CLK_DIV-timed 8-bit serial shift engine, MSB first.
//   clk, reset      - clock, synchronous active-high reset
//   start, tx_byte  - load tx_byte and begin shifting (ignored while active)
//   abort           - drop the current byte immediately, serial clock back high
//   sdi             - serial input, sampled in the last cycle of each low phase
//   sck, sdo        - serial clock (idles high) and serial output
//   done, rx_byte   - one-cycle pulse after the 8th high phase; received byte
module pram_shifter #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_byte,
  input  logic       sdi,
  output logic       sck,
  output logic       sdo,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int            HW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HP_LAST = HW'(CLK_DIV - 1);

  logic          active;
  logic          phase_hi;
  logic [HW-1:0] hp_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      active   <= 1'b0;
      phase_hi <= 1'b0;
      hp_cnt   <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sck      <= 1'b1;
    end else if (abort) begin
      active   <= 1'b0;
      phase_hi <= 1'b0;
      hp_cnt   <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b1;
    end else if (start && !active) begin
      // sck falls here and sdo presents bit 7 in the same cycle
      active   <= 1'b1;
      phase_hi <= 1'b0;
      hp_cnt   <= '0;
      bit_cnt  <= '0;
      tx_sh    <= tx_byte;
      sck      <= 1'b0;
    end else if (active) begin
      if (hp_cnt != HP_LAST) begin
        hp_cnt <= hp_cnt + HW'(1);
      end else begin
        hp_cnt <= '0;
        if (!phase_hi) begin
          rx_sh    <= {rx_sh[6:0], sdi};
          phase_hi <= 1'b1;
          sck      <= 1'b1;
        end else begin
          phase_hi <= 1'b0;
          bit_cnt  <= bit_cnt + 3'd1;   // wraps 7->0 at the byte boundary
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            // next bit moves onto sdo only as sck falls
            sck   <= 1'b0;
            tx_sh <= {tx_sh[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign sdo     = tx_sh[7];
  assign rx_byte = rx_sh;

endmodule

// File: rtl/pram_arb.sv
// pram_arb: shares the RTC serial bus between the VIA and a host engine that
// dumps or restores PRAM one byte per bus tenure.
//   clk, reset                   - clock, synchronous active-high reset
//   via_cs/via_ck/via_do/via_di  - VIA side of the RTC serial bus
//   rtc_cs/rtc_ck/rtc_din/rtc_dout - RTC side of the serial bus
//   host_start/host_dir          - job request (dir 0 = dump, 1 = restore)
//   host_busy/host_done          - job in progress / one-cycle end pulse
//   bk_addr/bk_wdata/bk_we/bk_rdata - backing store byte interface
//
// state      | meaning
// IDLE       | no job, VIA owns the bus
// WAIT_BUS   | wait for via_cs high IDLE_MIN consecutive cycles
// CS_SETUP   | host owns bus, rtc_cs low, clock high, restore byte fetched
// SHIFT_CMD  | shift out the command byte
// SHIFT_DATA | shift the data byte (out on restore, in on dump)
// CS_RELEASE | rtc_cs high, clock high
// NEXT       | finish byte, hand bus back to VIA or finish job
// DONE       | host_done pulse
module pram_arb
  import pram_arb_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int IDLE_MIN = 64,
  parameter int NBYTES   = PRAM_NBYTES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       via_cs,
  input  logic       via_ck,
  input  logic       via_do,
  output logic       via_di,
  output logic       rtc_cs,
  output logic       rtc_ck,
  output logic       rtc_din,
  input  logic       rtc_dout,
  input  logic       host_start,
  input  logic       host_dir,
  output logic       host_busy,
  output logic       host_done,
  output logic [4:0] bk_addr,
  output logic [7:0] bk_wdata,
  output logic       bk_we,
  input  logic [7:0] bk_rdata
);

  localparam int            HW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HP_LAST = HW'(CLK_DIV - 1);
  localparam int            IW      = $clog2(IDLE_MIN + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_MIN - 1);
  localparam logic [4:0]    IDX_LAST  = 5'(NBYTES - 1);

  arb_state_t    state, state_nx;
  owner_t        owner;
  logic          dir;
  logic [4:0]    idx;
  logic [IW-1:0] idle_cnt;
  logic [HW-1:0] hp_cnt;
  logic [7:0]    tx_data;

  logic          hp_last;
  logic          idle_hit;
  logic          coll;
  logic          sh_start;
  logic [7:0]    sh_tx;
  logic          sh_sck;
  logic          sh_sdo;
  logic          sh_done;
  logic [7:0]    sh_rx;
  logic          eng_cs;
  logic          eng_ck;

  assign hp_last  = (hp_cnt == HP_LAST);
  assign idle_hit = via_cs && (idle_cnt == IDLE_LAST);
  // The VIA reclaims the bus by pulling via_cs low while the host is mid-byte.
  assign coll = (owner == OWNER_HOST) && !via_cs &&
                (state inside {CS_SETUP, SHIFT_CMD, SHIFT_DATA});

  pram_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (sh_start),
    .abort   (coll),
    .tx_byte (sh_tx),
    .sdi     (rtc_dout),
    .sck     (sh_sck),
    .sdo     (sh_sdo),
    .done    (sh_done),
    .rx_byte (sh_rx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (host_start) state_nx = WAIT_BUS;
      WAIT_BUS:   if (idle_hit) state_nx = CS_SETUP;
      CS_SETUP:   if (coll) state_nx = WAIT_BUS;
                  else if (hp_last) state_nx = SHIFT_CMD;
      SHIFT_CMD:  if (coll) state_nx = WAIT_BUS;
                  else if (sh_done) state_nx = SHIFT_DATA;
      SHIFT_DATA: if (coll) state_nx = WAIT_BUS;
                  else if (sh_done) state_nx = CS_RELEASE;
      CS_RELEASE: if (hp_last) state_nx = NEXT;
      NEXT:       state_nx = (idx == IDX_LAST) ? DONE : WAIT_BUS;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    host_busy = (state != IDLE);
    host_done = (state == DONE);
    sh_start  = !coll && ((state == CS_SETUP && hp_last) ||
                          (state == SHIFT_CMD && sh_done));
    sh_tx     = (state == CS_SETUP) ? pram_cmd(!dir, idx) :
                (dir ? tx_data : 8'h00);
    eng_cs    = !(state inside {CS_SETUP, SHIFT_CMD, SHIFT_DATA});
    eng_ck    = (state inside {SHIFT_CMD, SHIFT_DATA}) ? sh_sck : 1'b1;
    if (owner == OWNER_VIA) begin
      rtc_cs  = via_cs;
      rtc_ck  = via_ck;
      rtc_din = via_do;
      via_di  = rtc_dout;
    end else begin
      rtc_cs  = eng_cs;
      rtc_ck  = eng_ck;
      rtc_din = sh_sdo;
      via_di  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= OWNER_VIA;
      dir      <= 1'b0;
      idx      <= '0;
      idle_cnt <= '0;
      hp_cnt   <= '0;
      tx_data  <= '0;
      bk_we    <= 1'b0;
      bk_wdata <= '0;
    end else begin
      bk_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host_start) begin
            dir <= host_dir;
            idx <= '0;
          end
        end
        WAIT_BUS: begin
          // After a collision the host holds rtc_cs high here for one
          // cycle so the RTC sees a clean deselect before the VIA's frame.
          if (owner == OWNER_HOST) owner <= OWNER_VIA;
          if (!via_cs) begin
            idle_cnt <= '0;
          end else if (idle_hit) begin
            idle_cnt <= '0;
            owner    <= OWNER_HOST;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        CS_SETUP: begin
          hp_cnt <= (hp_last || coll) ? '0 : hp_cnt + HW'(1);
          if (hp_last) tx_data <= bk_rdata;
        end
        SHIFT_CMD: begin
        end
        SHIFT_DATA: begin
          if (!coll && sh_done && !dir) begin
            bk_we    <= 1'b1;
            bk_wdata <= sh_rx;
          end
        end
        CS_RELEASE: begin
          hp_cnt <= hp_last ? '0 : hp_cnt + HW'(1);
        end
        NEXT: begin
          if (idx != IDX_LAST) begin
            idx   <= idx + 5'd1;
            owner <= OWNER_VIA;
          end
        end
        DONE: begin
          owner <= OWNER_VIA;
        end
        default: begin
        end
      endcase
    end
  end

  assign bk_addr = idx;

endmodule

// File: tb/tb_pram_arb.sv
module tb_pram_arb;
  localparam int CLK_DIV  = 4;
  localparam int IDLE_MIN = 64;
  localparam int NBYTES   = 20;
  localparam int JOB_LIMIT = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       via_cs = 1'b1;
  logic       via_ck = 1'b1;
  logic       via_do = 1'b1;
  logic       via_di;
  logic       rtc_cs;
  logic       rtc_ck;
  logic       rtc_din;
  logic       rtc_dout = 1'b1;
  logic       host_start = 1'b0;
  logic       host_dir = 1'b0;
  logic       host_busy;
  logic       host_done;
  logic [4:0] bk_addr;
  logic [7:0] bk_wdata;
  logic       bk_we;
  logic [7:0] bk_rdata = 8'h00;

  pram_arb #(.CLK_DIV(CLK_DIV), .IDLE_MIN(IDLE_MIN), .NBYTES(NBYTES)) dut (
    .clk(clk), .reset(reset),
    .via_cs(via_cs), .via_ck(via_ck), .via_do(via_do), .via_di(via_di),
    .rtc_cs(rtc_cs), .rtc_ck(rtc_ck), .rtc_din(rtc_din), .rtc_dout(rtc_dout),
    .host_start(host_start), .host_dir(host_dir),
    .host_busy(host_busy), .host_done(host_done),
    .bk_addr(bk_addr), .bk_wdata(bk_wdata), .bk_we(bk_we), .bk_rdata(bk_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- RTC model ----------------
  logic [7:0] mem [0:19] = '{8'hA8, 8'h00, 8'h00, 8'h22, 8'hCC, 8'h0A, 8'hCC, 8'h0A,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h63, 8'h00,
                             8'h03, 8'h88, 8'h00, 8'h6C};
  logic [7:0] dflt [0:19] = '{8'hA8, 8'h00, 8'h00, 8'h22, 8'hCC, 8'h0A, 8'hCC, 8'h0A,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h63, 8'h00,
                              8'h03, 8'h88, 8'h00, 8'h6C};
  logic       m_ck_q = 1'b1;
  int         m_bit = 0;
  logic [7:0] m_sh = 8'h00;
  logic [7:0] m_cmd = 8'h00;
  int         m_addr = 0;
  wire  [7:0] m_nsh = {m_sh[6:0], rtc_din};

  function automatic int decode(input logic [7:0] c);
    if (c[6]) return int'(c[5:2]);
    return 16 + int'(c[3:2]);
  endfunction

  always @(negedge clk) begin
    m_ck_q <= rtc_ck;
    if (rtc_cs) begin
      m_bit <= 0;
    end else if (rtc_ck && !m_ck_q) begin
      m_sh  <= m_nsh;
      m_bit <= m_bit + 1;
      if (m_bit == 7) begin
        m_cmd  <= m_nsh;
        m_addr <= decode(m_nsh);
      end
      if (m_bit == 15 && !m_cmd[7]) mem[m_addr] <= m_nsh;
    end else if (!rtc_ck && m_ck_q && m_bit >= 8 && m_bit < 16 && m_cmd[7]) begin
      rtc_dout <= mem[m_addr][15 - m_bit];
    end
  end

  // backing store read data, one cycle behind bk_addr
  always @(posedge clk) bk_rdata <= 8'h55 ^ {3'b000, bk_addr};

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [4:0] a; logic [7:0] d; } exp_t;
  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ck_toggles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic ck_prev;
    ck_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (host_done === 1'b1) done_cnt++;
      if (rtc_ck !== ck_prev) ck_toggles++;
      ck_prev = rtc_ck;
      if (!reset && bk_we === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bk_we_unexpected: actual addr=%0d data=0x%0h, required no write",
                   bk_addr, bk_wdata);
        end else begin
          e = sb_q.pop_front();
          chk("bk_addr", 32'(bk_addr), 32'(e.a));
          chk("bk_wdata", 32'(bk_wdata), 32'(e.d));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic d);
    tick(1);
    host_dir = d;
    host_start = 1'b1;
    tick(1);
    host_start = 1'b0;
  endtask

  task automatic push_dump(input logic use_default);
    exp_t e;
    for (int a = 0; a < NBYTES; a++) begin
      e.a = 5'(a);
      e.d = use_default ? dflt[a] : (8'h55 ^ 8'(a));
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < JOB_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_time"}, 32'(n < JOB_LIMIT), 32'd1);
    tick(20);
    chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
    chk({name, "_busy_low"}, 32'(host_busy), 32'd0);
  endtask

  task automatic via_bit(input logic b, output logic rx);
    via_ck = 1'b0;
    via_do = b;
    tick(CLK_DIV);
    rx = via_di;
    chk("via_pass_ck", 32'(rtc_ck), 32'(via_ck));
    chk("via_pass_din", 32'(rtc_din), 32'(via_do));
    via_ck = 1'b1;
    tick(CLK_DIV);
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    int n;
    int d0;
    int hi_cnt;
    logic [7:0] via_cmd;
    logic [7:0] via_rx;
    logic rb;

    tick(4);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(host_busy), 32'd0);
    chk("rst_done", 32'(host_done), 32'd0);
    chk("rst_we", 32'(bk_we), 32'd0);
    chk("rst_addr", 32'(bk_addr), 32'd0);
    chk("rst_wdata", 32'(bk_wdata), 32'd0);
    chk("rst_pass_cs", 32'(rtc_cs), 32'(via_cs));

    // 1: dump of default PRAM
    push_dump(1'b1);
    start_job(1'b0);
    wait_done("dump_default");

    // 2: restore 0x55^addr, then dump it back
    start_job(1'b1);
    wait_done("restore");
    for (int a = 0; a < NBYTES; a++)
      chk("restore_mem", 32'(mem[a]), 32'(8'h55 ^ 8'(a)));
    push_dump(1'b0);
    start_job(1'b0);
    wait_done("dump_restored");

    // 3: VIA collision during SHIFT_DATA of index 5
    push_dump(1'b0);
    start_job(1'b0);
    n = 0;
    while (!(bk_addr == 5'd5 && rtc_cs == 1'b0) && n < JOB_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("coll_reach_idx5", 32'(n < JOB_LIMIT), 32'd1);
    d0 = 0;
    n = 0;
    begin
      logic pk;
      pk = rtc_ck;
      while (d0 < 10 && n < 2000) begin
        @(negedge clk);
        n++;
        if (rtc_ck && !pk) d0++;
        pk = rtc_ck;
      end
    end
    chk("coll_reach_data", 32'(d0), 32'd10);
    tick(1);
    via_cs = 1'b0;
    hi_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rtc_cs) hi_cnt++;
    end
    chk("coll_cs_high_cycles", 32'(hi_cnt), 32'd1);
    chk("coll_pass_cs", 32'(rtc_cs), 32'(via_cs));
    tick(1);
    via_cmd = 8'hCD;   // read, low bank, index 3
    for (int b = 7; b >= 0; b--) via_bit(via_cmd[b], rb);
    for (int b = 7; b >= 0; b--) begin
      via_bit(1'b0, rb);
      via_rx[b] = rb;
    end
    chk("coll_via_read", 32'(via_rx), 32'h56);
    via_cs = 1'b1;
    wait_done("dump_coll");

    // 4: host_start while VIA holds the bus
    push_dump(1'b0);
    via_cs = 1'b0;
    tick(2);
    start_job(1'b0);
    d0 = ck_toggles;
    tick(1000);
    chk("hold_no_ck", 32'(ck_toggles - d0), 32'd0);
    chk("hold_busy", 32'(host_busy), 32'd1);
    chk("hold_cs_pass", 32'(rtc_cs), 32'd0);
    via_cs = 1'b1;
    n = 0;
    while (n < 500) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rtc_cs == 1'b0) break;
    end
    chk("hold_start_delay", 32'(n), 32'(IDLE_MIN));
    wait_done("dump_hold");

    // 5: reset during index 10
    push_dump(1'b0);
    start_job(1'b0);
    n = 0;
    while (bk_addr != 5'd10 && n < JOB_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reach_idx10", 32'(n < JOB_LIMIT), 32'd1);
    tick(100);
    d0 = done_cnt;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rstmid_busy", 32'(host_busy), 32'd0);
    chk("rstmid_done", 32'(host_done), 32'd0);
    chk("rstmid_we", 32'(bk_we), 32'd0);
    chk("rstmid_addr", 32'(bk_addr), 32'd0);
    chk("rstmid_wdata", 32'(bk_wdata), 32'd0);
    chk("rstmid_pass_cs", 32'(rtc_cs), 32'(via_cs));
    chk("rstmid_pass_di", 32'(via_di), 32'(rtc_dout));
    tick(300);
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    push_dump(1'b0);
    start_job(1'b0);
    wait_done("dump_after_reset");

    // 6: host_start while busy is ignored
    push_dump(1'b0);
    start_job(1'b0);
    tick(500);
    start_job(1'b1);
    wait_done("dump_busy_start");
    tick(400);
    chk("busy_start_idle", 32'(host_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
